ram_ctrl: RTL and testbench
===========================

RAM_CTRL -- requirements
Module: ram_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, word width in bits (legal 1..64).
REQ-002 SHALL have parameter ADDR_W, default 4, address width; DEPTH = 2**ADDR_W words.
REQ-003 SHALL have parameter RD_LAT, default 1, read latency in cycles (legal 1 or 2).
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port req_valid  input  1  request present.
REQ-007 SHALL have port req_ready  output  1  block can accept a request.
REQ-008 SHALL have port req_we  input  1  1 = write, 0 = read.
REQ-009 SHALL have port req_addr  input  ADDR_W  word address.
REQ-010 SHALL have port req_wdata  input  DATA_W  write data.
REQ-011 SHALL have port rsp_valid  output  1  read data valid, one-cycle pulse.
REQ-012 SHALL have port rsp_rdata  output  DATA_W  read data.
REQ-013 SHALL have port busy  output  1  clear sequence in progress.
REQ-014 SHALL have port par_err  output  1  parity mismatch on returned read.

Function
REQ-015 SHALL implement a two-state FSM: CLEAR (entered on reset) and RUN.
REQ-016 In CLEAR, SHALL write zero to addresses 0..DEPTH-1, one per cycle, via an ADDR_W-bit counter, with busy=1 and req_ready=0.
REQ-017 SHALL transition CLEAR->RUN on the cycle after writing address DEPTH-1; first cycle with req_ready=1 is cycle DEPTH+1 after reset release.
REQ-018 In RUN, req_ready SHALL be 1 continuously and busy SHALL be 0.
REQ-019 A request SHALL be accepted only on a cycle with req_valid=1 and req_ready=1; requests with req_ready=0 are ignored, not queued.
REQ-020 Accepted write SHALL update mem[req_addr] at that edge and SHALL produce no response.
REQ-021 Accepted read SHALL assert rsp_valid for exactly one cycle, RD_LAT cycles after the accept edge, with rsp_rdata = mem[req_addr].
REQ-022 Back-to-back reads on consecutive cycles SHALL return responses on consecutive cycles, in order, full throughput, no backpressure.
REQ-023 A read accepted the cycle after a write to the same address SHALL return the newly written data.
REQ-024 rsp_rdata SHALL hold its last value when rsp_valid=0.
REQ-025 req_addr is always in range (full width decoded); no wrap-around handling beyond natural ADDR_W truncation.

Reset
REQ-026 rst_n=0 SHALL asynchronously force: state=CLEAR, clear counter=0, req_ready=0, busy=1, rsp_valid=0, rsp_rdata=0, par_err=0, read pipeline flushed.
REQ-027 Reset asserted mid-read SHALL discard in-flight responses; none SHALL appear after release.
REQ-028 Reset asserted mid-CLEAR SHALL restart clearing from address 0.
REQ-029 Memory array contents SHALL NOT be reset directly; zeroing occurs only via CLEAR.

Configuration
REQ-030 Macro RAM_CTRL_PARITY_EN SHALL enable per-word even parity: one extra stored bit per word, written as XOR of write data (0 during CLEAR).
REQ-031 With RAM_CTRL_PARITY_EN, par_err SHALL equal 1 with rsp_valid when the stored parity mismatches recomputed parity of the read word, else 0.
REQ-032 Without RAM_CTRL_PARITY_EN, no parity storage SHALL exist and par_err SHALL be tied 0; port list unchanged.

Verification
REQ-033 Release reset, DEPTH=16 -> busy=1, req_ready=0 for cycles 1..16, req_ready=1 at cycle 17; reads of all addresses return 0x00.
REQ-034 Write 0xA5 to addr 3, read addr 3 next cycle -> rsp_valid RD_LAT cycles later, rsp_rdata=0xA5.
REQ-035 Reads of addrs 0,1,2 on three consecutive cycles after writing 0x11,0x22,0x33 -> three consecutive rsp_valid pulses with 0x11,0x22,0x33 in order, for RD_LAT=1 and 2.
REQ-036 Issue read, assert rst_n=0 before response -> rsp_valid stays 0; after release, CLEAR reruns and busy=1 for 16 cycles.
REQ-037 With RAM_CTRL_PARITY_EN: write 0x0F to addr 5, force-flip stored bit 0, read addr 5 -> rsp_rdata=0x0E, par_err=1; unflipped read -> par_err=0.
REQ-038 Request with req_valid=1 during CLEAR (write 0xFF addr 2) -> ignored; later read of addr 2 returns 0x00.

Source files
------------

// File: rtl/ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ram_ctrl
// Brief    : Single-port RAM controller with power-up clear sequence and
//            RD_LAT-cycle read pipeline. RAM_CTRL_PARITY_EN adds per-word
//            even parity and drives par_err.
// Revision : 1.0 - initial release
// ============================================================================
module ram_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic              par_err
);
    localparam int DEPTH = 2**ADDR_W;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              acc_rd;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] rd_word;
    logic              rd_perr;

    logic              pipe_v;
    logic [DATA_W-1:0] pipe_d;
    logic              pipe_e;

    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              par_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_ready = 1'b0;
        busy      = 1'b0;
        acc_rd    = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = cnt_q;
        mem_wdata = '0;
        case (state_q)
            ST_CLEAR: begin
                busy   = 1'b1;
                mem_we = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == {ADDR_W{1'b1}}) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                req_ready = 1'b1;
                acc_rd    = req_valid & ~req_we;
                mem_we    = req_valid & req_we;
                mem_waddr = req_addr;
                mem_wdata = req_wdata;
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    // Array is deliberately not reset; zeroing happens only through CLEAR.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign rd_word = mem_q[req_addr];

`ifdef RAM_CTRL_PARITY_EN
    logic par_q [DEPTH];

    always_ff @(posedge clk) begin
        if (mem_we) begin
            par_q[mem_waddr] <= ^mem_wdata;
        end
    end

    assign rd_perr = (^rd_word) != par_q[req_addr];
`else
    assign rd_perr = 1'b0;
`endif

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic              v1_q;
            logic [DATA_W-1:0] d1_q;
            logic              e1_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v1_q <= 1'b0;
                    d1_q <= '0;
                    e1_q <= 1'b0;
                end else begin
                    v1_q <= acc_rd;
                    if (acc_rd) begin
                        d1_q <= rd_word;
                        e1_q <= rd_perr;
                    end
                end
            end

            assign pipe_v = v1_q;
            assign pipe_d = d1_q;
            assign pipe_e = e1_q;
        end else begin : g_lat1
            assign pipe_v = acc_rd;
            assign pipe_d = rd_word;
            assign pipe_e = rd_perr;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            par_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= pipe_v;
            par_err_q   <= pipe_v & pipe_e;
            if (pipe_v) begin
                rsp_rdata_q <= pipe_d;
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign par_err   = par_err_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_ctrl
// Brief    : Scoreboard bench driving RD_LAT=1 and RD_LAT=2 instances of
//            ram_ctrl with shared stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_ctrl;
    localparam int NDUT = 2;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        int         acc;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_we = 1'b0;
    logic [3:0]      req_addr = '0;
    logic [7:0]      req_wdata = '0;
    logic [NDUT-1:0] rdy;
    logic [NDUT-1:0] rv;
    logic [NDUT-1:0] bsy;
    logic [NDUT-1:0] pe;
    logic [7:0]      rd [NDUT];

    exp_t       sb_q [NDUT][$];
    logic [7:0] model [16];
    logic [7:0] last [NDUT];
    logic       perr_next = 1'b0;
    exp_t       me;
    int         cyc = 0;
    int         n_chk = 0;
    int         n_err = 0;

    ram_ctrl #(.DATA_W(8), .ADDR_W(4), .RD_LAT(1)) u_lat1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy[0]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv[0]), .rsp_rdata(rd[0]), .busy(bsy[0]), .par_err(pe[0])
    );

    ram_ctrl #(.DATA_W(8), .ADDR_W(4), .RD_LAT(2)) u_lat2 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy[1]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv[1]), .rsp_rdata(rd[1]), .busy(bsy[1]), .par_err(pe[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Response monitor: instance i has read latency i+1.
    always @(negedge clk) begin
        for (int i = 0; i < NDUT; i++) begin
            if (!rst_n) last[i] = '0;
            if (sb_q[i].size() > 0 && (sb_q[i][0].acc + i) < cyc) begin
                chk($sformatf("missing_rsp%0d", i), {31'd0, rv[i]}, 32'd1);
                void'(sb_q[i].pop_front());
            end
            if (rv[i]) begin
                if (sb_q[i].size() == 0) begin
                    chk($sformatf("spurious_rsp%0d", i), {31'd0, rv[i]}, 32'd0);
                end else begin
                    me = sb_q[i].pop_front();
                    chk($sformatf("rdata%0d", i), {24'd0, rd[i]}, {24'd0, me.data});
                    chk($sformatf("par_err%0d", i), {31'd0, pe[i]}, {31'd0, me.perr});
                    chk($sformatf("latency%0d", i), cyc, me.acc + i);
                end
                last[i] = rd[i];
            end else begin
                chk($sformatf("rdata_hold%0d", i), {24'd0, rd[i]}, {24'd0, last[i]});
                chk($sformatf("par_err_idle%0d", i), {31'd0, pe[i]}, 32'd0);
            end
        end
    end

    task automatic req(input logic we, input logic [3:0] a, input logic [7:0] d);
        exp_t e;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        if (rdy[0]) begin
            if (we) begin
                model[a] = d;
            end else begin
                e.data = model[a];
                e.perr = perr_next;
                e.acc  = cyc + 1;
                for (int i = 0; i < NDUT; i++) sb_q[i].push_back(e);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
        end
    endtask

    task automatic do_reset(input bit hold_req);
        int n;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        for (int i = 0; i < NDUT; i++) sb_q[i].delete();
        for (int a = 0; a < 16; a++) model[a] = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_busy", {30'd0, bsy}, 32'd3);
        chk("rst_ready", {30'd0, rdy}, 32'd0);
        chk("rst_rsp_valid", {30'd0, rv}, 32'd0);
        chk("rst_par_err", {30'd0, pe}, 32'd0);
        chk("rst_rdata", {16'd0, rd[1], rd[0]}, 32'd0);
        if (hold_req) begin
            req_valid = 1'b1;
            req_we    = 1'b1;
            req_addr  = 4'd2;
            req_wdata = 8'hFF;
        end
        rst_n = 1'b1;
        n = 0;
        while (bsy[0] && n < 40) begin
            chk("clear_not_ready", {30'd0, rdy}, 32'd0);
            n++;
            @(negedge clk);
        end
        req_valid = 1'b0;
        chk("clear_cycles", n, 32'd16);
        chk("run_ready", {30'd0, rdy}, 32'd3);
        chk("run_busy", {30'd0, bsy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        do_reset(1'b1);

        // Everything reads back zero, including addr 2 written during CLEAR.
        for (int a = 0; a < 16; a++) req(1'b0, a[3:0], 8'h00);
        idle(4);

        req(1'b1, 4'd3, 8'hA5);
        req(1'b0, 4'd3, 8'h00);
        idle(4);

        req(1'b1, 4'd0, 8'h11);
        req(1'b1, 4'd1, 8'h22);
        req(1'b1, 4'd2, 8'h33);
        req(1'b0, 4'd0, 8'h00);
        req(1'b0, 4'd1, 8'h00);
        req(1'b0, 4'd2, 8'h00);
        idle(4);

        for (int k = 0; k < 80; k++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            else req(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom));
        end
        idle(4);

`ifdef RAM_CTRL_PARITY_EN
        req(1'b1, 4'd5, 8'h0F);
        idle(2);
        u_lat1.mem_q[5] = u_lat1.mem_q[5] ^ 8'h01;
        u_lat2.mem_q[5] = u_lat2.mem_q[5] ^ 8'h01;
        model[5]  = 8'h0E;
        perr_next = 1'b1;
        req(1'b0, 4'd5, 8'h00);
        idle(4);
        perr_next = 1'b0;
        req(1'b1, 4'd5, 8'h0F);
        req(1'b0, 4'd5, 8'h00);
        idle(4);
`endif

        // Reset lands right after a read is accepted; nothing may emerge.
        req(1'b1, 4'd15, 8'h77);
        req(1'b0, 4'd15, 8'h00);
        @(posedge clk);
        #1;
        do_reset(1'b0);
        req(1'b0, 4'd15, 8'h00);
        idle(4);

        // Reset in the middle of CLEAR must restart the sweep from address 0.
        req(1'b1, 4'd15, 8'h5A);
        idle(1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        do_reset(1'b0);
        req(1'b0, 4'd15, 8'h00);
        req(1'b0, 4'd0, 8'h00);
        idle(5);

        chk("sb_drained", sb_q[0].size() + sb_q[1].size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
